generator_arbiter: RTL and testbench

Round-robin scheduler that shares one alignment `generator` datapath among `NREQ` requesters. It arbitrates pending requests and re-arms the generator before each job. It then drives the generator's start/finish handshake, and returns the captured 32-bit solution, job cycle count and a timeout flag to the granted requester. It sits between the requester-side job logic and a single `generator` instance.

---
 rtl/generator_arbiter.sv | 172 +++++++++++++++++
 tb/tb_generator_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/generator_arbiter.sv
// ============================================================================
// generator_arbiter : round-robin sharing of one generator among NREQ users
// Rev 1.0
// ============================================================================
`default_nettype none

module generator_arbiter #(
   parameter int NREQ    = 4,
   parameter int SOL_W   = 32,
   parameter int CNT_W   = 24,
   parameter int TIMEOUT = 2**20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req_i,
   output logic [NREQ-1:0]  grant_o,
   output logic [NREQ-1:0]  done_o,
   output logic [SOL_W-1:0] solution_o,
   output logic [CNT_W-1:0] cycles_o,
   output logic             timeout_o,
   output logic             busy_o,
   output logic             gen_reset_o,
   output logic             gen_start_o,
   input  logic             gen_finish_i,
   input  logic [SOL_W-1:0] gen_solution_i
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

   logic [1:0]       state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SOL_W-1:0] sol_q, sol_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             busy_q, busy_d;
   logic             gen_reset_q, gen_reset_d;
   logic             gen_start_q, gen_start_d;

   logic             w_pick_vld;
   logic [IDX_W-1:0] w_pick_idx;
   logic [IDX_W-1:0] w_cand;
   logic [CNT_W-1:0] w_cnt_inc;

   // Search begins just after the previous owner so every requester gets a turn.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_idx = '0;
      w_cand     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = IDX_W'((int'(last_q) + k) % NREQ);
         if (!w_pick_vld && req_i[w_cand]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = w_cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      idx_d       = idx_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      sol_d       = sol_q;
      cycles_d    = cycles_q;
      done_d      = '0;
      timeout_d   = 1'b0;
      gen_reset_d = 1'b0;
      gen_start_d = 1'b0;
      w_cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (w_pick_vld) begin
               state_d     = S_CLEAR;
               grant_d     = NREQ'(1) << w_pick_idx;
               idx_d       = w_pick_idx;
               gen_reset_d = 1'b1;
            end
         end
         S_CLEAR: begin
            cnt_d       = '0;
            state_d     = S_RUN;
            gen_start_d = 1'b1;
         end
         S_RUN: begin
            cnt_d = w_cnt_inc;
            // Finish takes priority over a watchdog expiry in the same cycle.
            if (gen_finish_i) begin
               state_d  = S_DONE;
               sol_d    = gen_solution_i;
               cycles_d = w_cnt_inc;
               done_d   = grant_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_DONE;
               sol_d     = '0;
               cycles_d  = w_cnt_inc;
               done_d    = grant_q;
               timeout_d = 1'b1;
            end else begin
               gen_start_d = 1'b1;
            end
         end
         S_DONE: begin
            last_d  = idx_q;
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         idx_q       <= '0;
         last_q      <= IDX_LAST;
         cnt_q       <= '0;
         sol_q       <= '0;
         cycles_q    <= '0;
         done_q      <= '0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
         gen_reset_q <= 1'b1;
         gen_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         sol_q       <= sol_d;
         cycles_q    <= cycles_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         busy_q      <= busy_d;
         gen_reset_q <= gen_reset_d;
         gen_start_q <= gen_start_d;
      end
   end

   assign grant_o     = grant_q;
   assign done_o      = done_q;
   assign solution_o  = sol_q;
   assign cycles_o    = cycles_q;
   assign timeout_o   = timeout_q;
   assign busy_o      = busy_q;
   assign gen_reset_o = gen_reset_q;
   assign gen_start_o = gen_start_q;

endmodule

`default_nettype wire

// File: tb/tb_generator_arbiter.sv
// ============================================================================
// tb_generator_arbiter : directed bench with job-level model for generator_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_generator_arbiter;

   localparam int NREQ    = 4;
   localparam int SOL_W   = 32;
   localparam int CNT_W   = 24;
   localparam int TIMEOUT = 16;

   logic             clk;
   logic             reset;
   logic [NREQ-1:0]  req_i;
   logic [NREQ-1:0]  grant_o;
   logic [NREQ-1:0]  done_o;
   logic [SOL_W-1:0] solution_o;
   logic [CNT_W-1:0] cycles_o;
   logic             timeout_o;
   logic             busy_o;
   logic             gen_reset_o;
   logic             gen_start_o;
   logic             gen_finish_i;
   logic [SOL_W-1:0] gen_solution_i;

   int n_vec = 0;
   int n_err = 0;

   generator_arbiter #(
      .NREQ(NREQ), .SOL_W(SOL_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .grant_o(grant_o), .done_o(done_o),
      .solution_o(solution_o), .cycles_o(cycles_o), .timeout_o(timeout_o),
      .busy_o(busy_o), .gen_reset_o(gen_reset_o), .gen_start_o(gen_start_o),
      .gen_finish_i(gen_finish_i), .gen_solution_i(gen_solution_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Generator stand-in: raises finish after gen_target RUN cycles (0 = never).
   int gen_target = 0;
   int gen_run    = 0;
   always @(negedge clk) begin
      if (gen_start_o) begin
         gen_run++;
         gen_finish_i = (gen_target != 0) && (gen_run >= gen_target);
      end else begin
         gen_run      = 0;
         gen_finish_i = 1'b0;
      end
   end

   // Job-level model: owner, position in the job timeline, and last served index.
   int               m_owner, m_last, m_stage, m_run;
   logic [NREQ-1:0]  e_grant, e_done;
   logic [SOL_W-1:0] e_sol;
   logic [CNT_W-1:0] e_cyc;
   logic             e_to, e_busy, e_gr, e_gs;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_owner = -1; m_last = NREQ - 1; m_stage = 0; m_run = 0;
         e_grant = '0; e_done = '0; e_sol = '0; e_cyc = '0;
         e_to = 1'b0; e_busy = 1'b0; e_gr = 1'b1; e_gs = 1'b0;
      end else if (m_owner < 0) begin
         e_done = '0; e_to = 1'b0; e_gr = 1'b0;
         for (int k = 1; k <= NREQ; k++)
            if (m_owner < 0 && req_i[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
         if (m_owner >= 0) begin
            e_grant = NREQ'(1) << m_owner;
            e_busy  = 1'b1;
            e_gr    = 1'b1;
            m_stage = 0;
         end
      end else if (m_stage == 0) begin
         e_gr = 1'b0; e_gs = 1'b1; m_stage = 1; m_run = 0;
      end else if (m_stage == 1) begin
         m_run++;
         if (gen_finish_i || m_run == TIMEOUT) begin
            e_gs    = 1'b0;
            e_done  = e_grant;
            e_cyc   = CNT_W'(m_run);
            e_to    = !gen_finish_i;
            e_sol   = gen_finish_i ? gen_solution_i : '0;
            m_stage = 2;
         end
      end else begin
         m_last = m_owner; m_owner = -1;
         e_grant = '0; e_busy = 1'b0; e_done = '0; e_to = 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("grant_o", grant_o, e_grant);
      chk("done_o", done_o, e_done);
      chk("solution_o", solution_o, e_sol);
      chk("cycles_o", cycles_o, e_cyc);
      chk("timeout_o", timeout_o, e_to);
      chk("busy_o", busy_o, e_busy);
      chk("gen_reset_o", gen_reset_o, e_gr);
      chk("gen_start_o", gen_start_o, e_gs);
   end

   task automatic wait_done(input int budget, output int gr_cycles);
      logic seen;
      seen = 1'b0;
      gr_cycles = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (gen_reset_o) gr_cycles++;
         if (done_o != '0) seen = 1'b1;
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_done: no done_o within %0d cycles", budget);
      end
   endtask

   task automatic wait_start(input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (gen_start_o) seen = 1'b1;
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_start: no gen_start_o within %0d cycles", budget);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int gr;
      logic [NREQ-1:0] order [5];
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;

      reset = 1'b1; req_i = '0; gen_solution_i = '0; gen_finish_i = 1'b0;
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst grant_o", grant_o, 4'b0000);
      chk("rst busy_o", busy_o, 1'b0);
      chk("rst gen_reset_o", gen_reset_o, 1'b1);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Single request, finishes after 5 RUN cycles.
      gen_target = 5; gen_solution_i = 32'h0000_1234; req_i = 4'b0001;
      wait_done(40, gr);
      chk("single done_o", done_o, 4'b0001);
      chk("single solution_o", solution_o, 32'h1234);
      chk("single cycles_o", cycles_o, 5);
      chk("single timeout_o", timeout_o, 1'b0);
      chk("single gen_reset pulses", gr, 1);
      req_i = '0;
      @(negedge clk);
      chk("single done one cycle", done_o, 4'b0000);
      repeat (2) @(negedge clk);

      // Round-robin from a fresh reset with all four requesting.
      pulse_reset();
      gen_target = 3; gen_solution_i = 32'hA5A5_0003; req_i = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         wait_done(40, gr);
         chk("rr done_o", done_o, order[j]);
         chk("rr cycles_o", cycles_o, 3);
         if (j == 4) req_i = '0;
      end
      repeat (3) @(negedge clk);

      // Fairness: serve 2 alone, then 0 and 2 together -> 0 first.
      gen_target = 2; gen_solution_i = 32'h0000_0202; req_i = 4'b0100;
      wait_done(40, gr);
      chk("fair solo done_o", done_o, 4'b0100);
      req_i = '0;
      repeat (3) @(negedge clk);
      req_i = 4'b0101;
      wait_done(40, gr);
      chk("fair first done_o", done_o, 4'b0001);
      req_i = 4'b0100;
      wait_done(40, gr);
      chk("fair second done_o", done_o, 4'b0100);
      req_i = '0;
      repeat (3) @(negedge clk);

      // Watchdog: generator never finishes.
      gen_target = 0; gen_solution_i = 32'hDEAD_BEEF; req_i = 4'b1000;
      wait_done(60, gr);
      chk("wd done_o", done_o, 4'b1000);
      chk("wd timeout_o", timeout_o, 1'b1);
      chk("wd solution_o", solution_o, 32'h0);
      chk("wd cycles_o", cycles_o, 16);
      chk("wd gen_start_o", gen_start_o, 1'b0);
      req_i = '0;
      repeat (3) @(negedge clk);

      // Finish coincides with the watchdog limit.
      gen_target = 16; gen_solution_i = 32'hCAFE_F00D; req_i = 4'b0010;
      wait_done(60, gr);
      chk("coll timeout_o", timeout_o, 1'b0);
      chk("coll solution_o", solution_o, 32'hCAFE_F00D);
      chk("coll cycles_o", cycles_o, 16);
      req_i = '0;
      repeat (3) @(negedge clk);

      // Owner withdraws its request mid-RUN.
      gen_target = 4; gen_solution_i = 32'h0000_0055; req_i = 4'b0100;
      wait_start(20);
      @(negedge clk); req_i = '0;
      wait_done(40, gr);
      chk("drop done_o", done_o, 4'b0100);
      chk("drop cycles_o", cycles_o, 4);
      chk("drop solution_o", solution_o, 32'h55);
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of a RUN cycle.
      gen_target = 0; req_i = 4'b0001;
      wait_start(20);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("areset grant_o", grant_o, 4'b0000);
      chk("areset busy_o", busy_o, 1'b0);
      chk("areset gen_start_o", gen_start_o, 1'b0);
      chk("areset gen_reset_o", gen_reset_o, 1'b1);
      chk("areset done_o", done_o, 4'b0000);
      chk("areset cycles_o", cycles_o, 0);
      @(negedge clk);
      reset = 1'b1; gen_target = 3; gen_solution_i = 32'h0000_0777; req_i = 4'b0010;
      wait_done(40, gr);
      chk("post-reset done_o", done_o, 4'b0010);
      chk("post-reset cycles_o", cycles_o, 3);
      req_i = '0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
